muldiv_seq: RTL and testbench

- Sequential RISC-V M-extension unit for the equaliser core; successor to the combinational multiply-only block.
- Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU with a start/busy/done handshake. Operand width and fixed-point MULH alignment are parametrised.
- Multiplies complete in 2 cycles. Divides use a serial radix-2 core taking DWIDTH+2 cycles. Sits beside the ALU and stalls the pipeline while busy.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/div_iter.sv | 59 +++++
 rtl/muldiv_seq.sv | 203 ++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the sequential M-extension multiply/divide unit.
// Op codes follow the funct3 encoding of the RISC-V M extension.
// FSM state encoding is shared so the top and any debug taps agree.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_func_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_t;

  // True for the four divide/remainder op codes.
  function automatic logic is_div(input md_func_t f);
    return f inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

endpackage

// File: rtl/div_iter.sv
// Serial unsigned restoring divider: one quotient bit per clock after load.
// Latency: DWIDTH edges from the load edge; last is high before the final step.
// No backpressure: a new load restarts it, results hold once the count expires.
module div_iter #(
  parameter int DWIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DWIDTH-1:0] dividend,
  input  logic [DWIDTH-1:0] divisor,
  output logic [DWIDTH-1:0] quotient,
  output logic [DWIDTH-1:0] remainder,
  output logic              last
);

  localparam int CW = $clog2(DWIDTH + 1);

  logic [DWIDTH-1:0] r_rem;
  logic [DWIDTH-1:0] r_quo;
  logic [DWIDTH-1:0] r_dvs;
  logic [CW-1:0]     r_cnt;

  logic [DWIDTH:0]   w_shift;
  logic [DWIDTH:0]   w_trial;

  // Partial remainder shifted left with the next dividend bit, then trial-subtracted.
  assign w_shift = {r_rem, r_quo[DWIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};

  // Load operands, then retire one quotient bit per edge until the count runs out.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_rem <= '0;
      r_quo <= dividend;
      r_dvs <= divisor;
      r_cnt <= CW'(DWIDTH);
    end else if (r_cnt != '0) begin
      if (!w_trial[DWIDTH]) begin
        r_rem <= w_trial[DWIDTH-1:0];
        r_quo <= {r_quo[DWIDTH-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[DWIDTH-1:0];
        r_quo <= {r_quo[DWIDTH-2:0], 1'b0};
      end
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign last      = (r_cnt == CW'(1));

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RISC-V M-extension unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
// Latency: multiplies and divide special cases 2 edges, regular divides DWIDTH+2.
// Start is only taken while busy is low; kill aborts, the pipeline stalls on busy.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int FRAC_BITS = 29
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              kill,
  input  logic [2:0]        MDFunc,
  input  logic [DWIDTH-1:0] A,
  input  logic [DWIDTH-1:0] B,
  output logic [DWIDTH-1:0] MDOut,
  output logic              busy,
  output logic              done
);

  localparam logic [DWIDTH-1:0] MOST_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

  md_state_t           r_state;
  md_func_t            r_func;
  logic [DWIDTH-1:0]   r_a;
  logic [DWIDTH-1:0]   r_b;
  logic [2*DWIDTH-1:0] r_prod;
  logic [DWIDTH-1:0]   r_res;
  logic                r_ph;
  logic [DWIDTH-1:0]   r_mdout;
  logic                r_busy;
  logic                r_done;

  // Input-side decode used on the accepting edge.
  md_func_t          w_in_func;
  logic              w_in_sgn;
  logic              w_in_special;
  logic              w_accept;
  logic              w_div_load;
  logic [DWIDTH-1:0] w_a_mag;
  logic [DWIDTH-1:0] w_b_mag;

  assign w_in_func    = md_func_t'(MDFunc);
  assign w_in_sgn     = ~MDFunc[0];
  assign w_in_special = (B == '0) | (w_in_sgn & (A == MOST_NEG) & (B == '1));
  assign w_a_mag      = (w_in_sgn && A[DWIDTH-1]) ? -A : A;
  assign w_b_mag      = (w_in_sgn && B[DWIDTH-1]) ? -B : B;
  assign w_accept     = start & ~r_busy & ~kill & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_div_load   = w_accept & is_div(w_in_func) & ~w_in_special;

  // Multiply datapath: sign-extend each operand according to the op, then one wide multiply.
  logic                w_a_sgn;
  logic                w_b_sgn;
  logic [2*DWIDTH-1:0] w_a_ext;
  logic [2*DWIDTH-1:0] w_b_ext;
  logic [2*DWIDTH-1:0] w_prod;
  logic [DWIDTH-1:0]   w_mul_res;

  assign w_a_sgn = (r_func == MD_MUL) | (r_func == MD_MULH) | (r_func == MD_MULHSU);
  assign w_b_sgn = (r_func == MD_MUL) | (r_func == MD_MULH);
  assign w_a_ext = {{DWIDTH{w_a_sgn & r_a[DWIDTH-1]}}, r_a};
  assign w_b_ext = {{DWIDTH{w_b_sgn & r_b[DWIDTH-1]}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Pick the result word: low half, fixed-point MULH window, or high half.
  always_comb begin
    w_mul_res = r_prod[2*DWIDTH-1:DWIDTH];
    case (r_func)
      MD_MUL:  w_mul_res = r_prod[DWIDTH-1:0];
      MD_MULH: w_mul_res = r_prod[FRAC_BITS +: DWIDTH];
      default: w_mul_res = r_prod[2*DWIDTH-1:DWIDTH];
    endcase
  end

  // Divide datapath: the core works on magnitudes, signs are restored in FIX.
  logic [DWIDTH-1:0] w_quo;
  logic [DWIDTH-1:0] w_rem;
  logic              w_last;

  div_iter #(
    .DWIDTH (DWIDTH)
  ) u_div_iter (
    .clock     (clock),
    .reset     (reset),
    .load      (w_div_load),
    .dividend  (w_a_mag),
    .divisor   (w_b_mag),
    .quotient  (w_quo),
    .remainder (w_rem),
    .last      (w_last)
  );

  logic              w_r_sgn;
  logic              w_r_dz;
  logic              w_r_ovf;
  logic              w_neg_q;
  logic              w_neg_r;
  logic [DWIDTH-1:0] w_fix_res;

  assign w_r_sgn = ~r_func[0];
  assign w_r_dz  = (r_b == '0);
  assign w_r_ovf = w_r_sgn & (r_a == MOST_NEG) & (r_b == '1);
  assign w_neg_q = w_r_sgn & (r_a[DWIDTH-1] ^ r_b[DWIDTH-1]);
  assign w_neg_r = w_r_sgn & r_a[DWIDTH-1];

  // Final divide result: special cases first, else signed fix-up of quotient/remainder.
  always_comb begin
    w_fix_res = '0;
    if (w_r_dz) begin
      w_fix_res = r_func[1] ? r_a : '1;
    end else if (w_r_ovf) begin
      w_fix_res = r_func[1] ? '0 : r_a;
    end else if (r_func[1]) begin
      w_fix_res = w_neg_r ? -w_rem : w_rem;
    end else begin
      w_fix_res = w_neg_q ? -w_quo : w_quo;
    end
  end

  // Control FSM with registered result and handshake outputs; kill beats everything but reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_func  <= MD_MUL;
      r_a     <= '0;
      r_b     <= '0;
      r_prod  <= '0;
      r_res   <= '0;
      r_ph    <= 1'b0;
      r_mdout <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (kill) begin
      r_state <= ST_IDLE;
      r_ph    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          r_ph   <= 1'b0;
          if (w_accept) begin
            r_func <= w_in_func;
            r_a    <= A;
            r_b    <= B;
            r_busy <= 1'b1;
            if (!is_div(w_in_func)) begin
              r_state <= ST_MUL;
            end else if (w_in_special) begin
              r_state <= ST_FIX;
            end else begin
              r_state <= ST_DIV;
            end
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_MUL: begin
          if (!r_ph) begin
            r_prod <= w_prod;
            r_ph   <= 1'b1;
          end else begin
            r_mdout <= w_mul_res;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_ph    <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_DIV: begin
          if (w_last) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (!r_ph) begin
            r_res <= w_fix_res;
            r_ph  <= 1'b1;
          end else begin
            r_mdout <= r_res;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_ph    <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign MDOut = r_mdout;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq (DWIDTH=32, FRAC_BITS=29): directed cases with literal
// expectations, then randomized start/kill/reset traffic checked every cycle
// against an arithmetic reference model.
module tb_muldiv_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic        kill;
  logic [2:0]  MDFunc;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] MDOut;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  muldiv_seq #(
    .DWIDTH    (32),
    .FRAC_BITS (29)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .kill   (kill),
    .MDFunc (MDFunc),
    .A      (A),
    .B      (B),
    .MDOut  (MDOut),
    .busy   (busy),
    .done   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result straight from the M-extension arithmetic rules.
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          ub;
    longint unsigned pu;
    logic [63:0]     p;
    int              ia;
    int              ib;
    logic [31:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    r  = '0;
    p  = '0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; p = p >> 29; r = p[31:0]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin pu = {32'd0, a} * {32'd0, b}; p = pu; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = ia / ib;
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = ia % ib;
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Edges from acceptance to done.
  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 2;
    if (b == 0) return 2;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = $urandom_range(0, 20);
      4:       v = -$urandom_range(1, 20);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Cycle model: what done/busy/MDOut must be, updated from the inputs about to be sampled.
  logic        m_pend = 1'b0;
  int          m_due  = 0;
  logic [31:0] m_val  = '0;
  logic [31:0] m_out  = '0;

  always @(negedge clock) begin
    logic e_done;
    logic e_busy;
    if (cyc >= 1) begin
      e_done = m_pend && (cyc == m_due);
      e_busy = m_pend && (cyc < m_due);
      if (e_done) begin
        m_out  = m_val;
        m_pend = 1'b0;
      end
      check("mon_done",  {31'd0, done}, {31'd0, e_done});
      check("mon_busy",  {31'd0, busy}, {31'd0, e_busy});
      check("mon_mdout", MDOut, m_out);
      if (reset) begin
        m_pend = 1'b0;
        m_out  = '0;
      end else if (kill) begin
        m_pend = 1'b0;
      end else if (start && !e_busy) begin
        m_pend = 1'b1;
        m_due  = cyc + 1 + ref_lat(MDFunc, A, B);
        m_val  = ref_res(MDFunc, A, B);
      end
    end
  end

  // Issue one op (caller sits just after a rising edge) and check result and latency.
  task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int k;
    start  = 1'b1;
    MDFunc = f;
    A      = a;
    B      = b;
    @(posedge clock); #1;
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    k     = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clock); #1;
      if (done) begin
        k = i;
        break;
      end
    end
    if (k == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no done within 60 edges", name);
    end else begin
      check({name, "_lat"}, k, exp_lat);
      check(name, MDOut, exp);
    end
  endtask

  initial begin
    logic seen;
    reset  = 1'b1;
    start  = 1'b0;
    kill   = 1'b0;
    MDFunc = 3'd0;
    A      = '0;
    B      = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_mdout", MDOut, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    reset = 1'b0;

    // Pin the reference model to hand-computed values.
    check("ref_mul",    ref_res(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("ref_mulh",   ref_res(3'd1, 32'h2000_0000, 32'h3000_0000), 32'h3000_0000);
    check("ref_mulhu",  ref_res(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    check("ref_div",    ref_res(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("ref_rem",    ref_res(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("ref_divu",   ref_res(3'd5, 32'd100, 32'd7), 32'd14);
    check("ref_remu",   ref_res(3'd7, 32'd100, 32'd7), 32'd2);
    check("ref_ovf",    ref_res(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("ref_mulhsu", ref_res(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);

    // Directed operations with literal results and latencies.
    do_op("mul",      3'd0, 32'd7,           32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
    do_op("mulh_fx",  3'd1, 32'h2000_0000,   32'h3000_0000, 32'h3000_0000, 2);
    do_op("mulhu",    3'd3, 32'hFFFF_FFFF,   32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    do_op("mulhsu",   3'd2, 32'hFFFF_FFFF,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    do_op("div",      3'd4, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFD, 34);
    do_op("rem",      3'd6, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFF, 34);
    do_op("divu",     3'd5, 32'd100,         32'd7,         32'd14,        34);
    do_op("remu",     3'd7, 32'd100,         32'd7,         32'd2,         34);
    do_op("divu_z",   3'd5, 32'd5,           32'd0,         32'hFFFF_FFFF, 2);
    do_op("rem_z",    3'd6, 32'd5,           32'd0,         32'd5,         2);
    do_op("div_ovf",  3'd4, 32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000, 2);
    do_op("rem_ovf",  3'd6, 32'h8000_0000,   32'hFFFF_FFFF, 32'd0,         2);
    do_op("divu_pre", 3'd5, 32'd100,         32'd7,         32'd14,        34);

    // Abort: DIV 1000/3, ignored MUL start at edge 5, kill at edge 10.
    start = 1'b1; MDFunc = 3'd4; A = 32'd1000; B = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    start = 1'b1; MDFunc = 3'd0; A = 32'd6; B = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    kill = 1'b1;
    @(posedge clock); #1;
    kill = 1'b0;
    check("kill_busy",  {31'd0, busy}, 32'd0);
    check("kill_mdout", MDOut, 32'd14);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) seen = 1'b1;
    end
    check("kill_nodone", {31'd0, seen}, 32'd0);
    do_op("mul_after_kill", 3'd0, 32'd6, 32'd7, 32'd42, 2);

    // Back-to-back: each do_op returns in the DONE cycle, so the next start lands there.
    do_op("b2b_first",  3'd0, 32'd9,  32'd9,  32'd81, 2);
    do_op("b2b_second", 3'd0, 32'd12, 32'd11, 32'd132, 2);

    // Reset in the middle of a divide.
    start = 1'b1; MDFunc = 3'd5; A = 32'd12345; B = 32'd17;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midrst_mdout", MDOut, 32'd0);
    check("midrst_busy",  {31'd0, busy}, 32'd0);
    check("midrst_done",  {31'd0, done}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) seen = 1'b1;
    end
    check("midrst_nodone", {31'd0, seen}, 32'd0);

    // Randomized traffic; the cycle model checks every output every cycle.
    for (int i = 0; i < 4000; i++) begin
      start  = ($urandom_range(0, 1) == 1);
      kill   = ($urandom_range(0, 149) == 0);
      reset  = ($urandom_range(0, 999) == 0);
      MDFunc = 3'($urandom_range(0, 7));
      A      = rnd_opnd();
      B      = rnd_opnd();
      @(posedge clock); #1;
    end
    start = 1'b0;
    kill  = 1'b0;
    reset = 1'b0;
    repeat (40) @(posedge clock);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
